// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit scheduler.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 6;
    localparam int DEF_GAP    = 1;

    // LSB position of requester idx's word inside the flattened data bus.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request after the last winner, with wrap.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    input  logic           advance,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (advance && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler sharing one MSB-first serial lane between N_REQ producers,
// framing each word with sof/eof markers followed by an idle gap.
module serial_tx_scheduler
    import serial_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int GAP    = DEF_GAP,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    output logic [N_REQ-1:0]        ack,
    output logic                    ser_out,
    output logic                    ser_valid,
    output logic                    ser_sof,
    output logic                    ser_eof,
    output logic [ID_W-1:0]         src_id,
    output logic                    busy
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              state_reg, state_next;
    logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [3:0]          gap_cnt_reg, gap_cnt_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic [ID_W-1:0]     last_reg, last_next;
    logic [ID_W-1:0]     src_id_reg, src_id_next;
    logic [N_REQ-1:0]    ack_reg, ack_next;
    logic                ser_out_reg, ser_out_next;
    logic                valid_reg, valid_next;
    logic                sof_reg, sof_next;
    logic                eof_reg, eof_next;
    logic                busy_reg, busy_next;

    logic                advance;
    logic [N_REQ-1:0]    grant;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   word_arr [N_REQ];
    logic [DATA_W-1:0]   win_word;
    logic [BIT_W-1:0]    next_bit;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
        assign word_arr[gi] = data_in[slice_lsb(gi, DATA_W) +: DATA_W];
    end

    assign win_word = word_arr[grant_idx];
    assign next_bit = bit_cnt_reg - 1'b1;

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (ID_W)
    ) u_arb (
        .req       (req),
        .last      (last_reg),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        shift_next   = shift_reg;
        last_next    = last_reg;
        src_id_next  = src_id_reg;
        ack_next     = '0;
        ser_out_next = ser_out_reg;
        valid_next   = 1'b0;
        sof_next     = 1'b0;
        eof_next     = 1'b0;
        advance      = 1'b0;
        // A stalled edge freezes everything; only the strobes fall to 0.
        if (enable) begin
            unique case (state_reg)
                ST_IDLE: begin
                    advance = 1'b1;
                    if (|req) begin
                        state_next   = ST_SHIFT;
                        shift_next   = win_word;
                        bit_cnt_next = BIT_W'(DATA_W - 1);
                        last_next    = grant_idx;
                        src_id_next  = grant_idx;
                        ack_next     = grant;
                        ser_out_next = win_word[DATA_W-1];
                        valid_next   = 1'b1;
                        sof_next     = 1'b1;
                        eof_next     = (DATA_W == 1);
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_reg == '0) begin
                        state_next   = (GAP > 0) ? ST_GAP : ST_IDLE;
                        gap_cnt_next = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
                    end else begin
                        bit_cnt_next = next_bit;
                        ser_out_next = shift_reg[next_bit];
                        valid_next   = 1'b1;
                        eof_next     = (next_bit == '0);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == 4'd0) begin
                        state_next = ST_IDLE;
                    end else begin
                        gap_cnt_next = gap_cnt_reg - 4'd1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            shift_reg   <= '0;
            last_reg    <= ID_W'(N_REQ - 1);
            src_id_reg  <= '0;
            ack_reg     <= '0;
            ser_out_reg <= 1'b0;
            valid_reg   <= 1'b0;
            sof_reg     <= 1'b0;
            eof_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            shift_reg   <= shift_next;
            last_reg    <= last_next;
            src_id_reg  <= src_id_next;
            ack_reg     <= ack_next;
            ser_out_reg <= ser_out_next;
            valid_reg   <= valid_next;
            sof_reg     <= sof_next;
            eof_reg     <= eof_next;
            busy_reg    <= busy_next;
        end
    end

    assign ack       = ack_reg;
    assign ser_out   = ser_out_reg;
    assign ser_valid = valid_reg;
    assign ser_sof   = sof_reg;
    assign ser_eof   = eof_reg;
    assign src_id    = src_id_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Scoreboard bench: expected frames are queued at stimulus time and matched as the serial stream completes.
module tb_serial_tx_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  req;
    logic [23:0] data_in;
    logic [3:0]  ack;
    logic        ser_out, ser_valid, ser_sof, ser_eof;
    logic [1:0]  src_id;
    logic        busy;

    serial_tx_scheduler #(.N_REQ(4), .DATA_W(6), .GAP(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_sof   (ser_sof),
        .ser_eof   (ser_eof),
        .src_id    (src_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         src;
        logic [5:0] word;
    } exp_t;

    typedef struct {
        bit          rst_before;
        logic [3:0]  req;
        logic [23:0] data;
        int          exp_src;
        logic [5:0]  exp_word;
    } vec_t;

    exp_t       sb[$];
    exp_t       popped;
    vec_t       tbl [8];
    int         n_cmp = 0;
    int         n_err = 0;
    int         frames_done = 0;
    bit         auto_drop = 1'b1;
    bit         in_frame = 1'b0;
    int         bits_seen = 0;
    logic [5:0] acc = '0;
    bit         exp_v [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    bit         exp_b [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    bit         exp_s [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    bit         exp_e [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic [5:0] t1_word = 6'b101010;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pack4(input logic [5:0] w3, input logic [5:0] w2,
                                          input logic [5:0] w1, input logic [5:0] w0);
        return {w3, w2, w1, w0};
    endfunction

    task automatic set_word(input int i, input logic [5:0] w);
        data_in[i*6 +: 6] = w;
    endtask

    // Sample half a cycle after the active edge; a requester drops req once it sees ack.
    task automatic tick();
        @(negedge clk);
        #1;
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            tick();
            n++;
        end
        if (frames_done < target) chk("frame_timeout", frames_done, target);
    endtask

    task automatic wait_sof(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ser_sof && n < budget);
        chk("sof_seen", ser_sof, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {ack, ser_out, ser_valid, ser_sof, ser_eof, src_id, busy}, 0);
        sb.delete();
        reset = 1'b1;
    endtask

    // Reassembles frames from the serial stream and retires scoreboard entries.
    always @(negedge clk) begin
        if (!reset) begin
            in_frame  = 1'b0;
            bits_seen = 0;
        end else if (ser_valid) begin
            if (ser_sof) begin
                chk("sof_inside_frame", in_frame, 0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_frame: got frame from src %0d, want none", src_id);
                end else begin
                    chk("ack_at_sof", ack, 32'(1) << sb[0].src);
                    chk("src_id_at_sof", src_id, sb[0].src);
                end
                in_frame  = 1'b1;
                bits_seen = 0;
                acc       = '0;
            end else begin
                chk("ack_mid_frame", ack, 0);
            end
            acc = {acc[4:0], ser_out};
            bits_seen++;
            if (ser_eof) begin
                chk("eof_bitcount", bits_seen, 6);
                if (sb.size() > 0) begin
                    popped = sb.pop_front();
                    chk("frame_word", acc, popped.word);
                    $display("frame src=%0d word=%b expected src=%0d word=%b",
                             src_id, acc, popped.src, popped.word);
                end
                frames_done++;
                in_frame  = 1'b0;
                bits_seen = 0;
            end
        end
    end

    initial begin
        reset   = 1'b0;
        enable  = 1'b1;
        req     = '0;
        data_in = '0;
        tbl[0] = '{1'b1, 4'b0011, pack4(6'd0, 6'd0, 6'b000111, 6'b110011), 0, 6'b110011};
        tbl[1] = '{1'b0, 4'b0011, pack4(6'd0, 6'd0, 6'b000111, 6'b110011), 1, 6'b000111};
        tbl[2] = '{1'b1, 4'b1111, pack4(6'b111000, 6'b001100, 6'b010010, 6'b100001), 0, 6'b100001};
        tbl[3] = '{1'b0, 4'b1111, pack4(6'b111000, 6'b001100, 6'b010010, 6'b100001), 1, 6'b010010};
        tbl[4] = '{1'b0, 4'b1111, pack4(6'b111000, 6'b001100, 6'b010010, 6'b100001), 2, 6'b001100};
        tbl[5] = '{1'b0, 4'b1111, pack4(6'b111000, 6'b001100, 6'b010010, 6'b100001), 3, 6'b111000};
        tbl[6] = '{1'b0, 4'b1111, pack4(6'b111000, 6'b001100, 6'b010010, 6'b100001), 0, 6'b100001};
        tbl[7] = '{1'b0, 4'b1000, pack4(6'b010101, 6'd0, 6'd0, 6'd0), 3, 6'b010101};

        repeat (3) tick();
        chk("reset_outputs", {ack, ser_out, ser_valid, ser_sof, ser_eof, src_id, busy}, 0);
        reset = 1'b1;
        repeat (2) tick();
        chk("idle_no_req", {ack, ser_out, ser_valid, ser_sof, ser_eof, src_id, busy}, 0);

        // Single frame traced cycle by cycle, including the gap.
        set_word(0, t1_word);
        req = 4'b0001;
        sb.push_back('{0, t1_word});
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 0) chk("t1_ack", ack, 4'b0001);
            chk($sformatf("t1_valid[%0d]", c), ser_valid, exp_v[c]);
            chk($sformatf("t1_busy[%0d]", c), busy, exp_b[c]);
            chk($sformatf("t1_sof[%0d]", c), ser_sof, exp_s[c]);
            chk($sformatf("t1_eof[%0d]", c), ser_eof, exp_e[c]);
            if (c < 6) chk($sformatf("t1_bit[%0d]", c), ser_out, t1_word[5-c]);
        end
        chk("t1_frames", frames_done, 1);

        // Overwrite the granted word during its ack cycle.
        set_word(1, 6'b101010);
        req = 4'b0010;
        sb.push_back('{1, 6'b101010});
        for (int n = 0; n < 20; n++) begin
            tick();
            if (ack[1]) begin
                set_word(1, 6'b000000);
                break;
            end
        end
        wait_frames(2, 30);

        // Stall for three edges after bit 3 has been presented.
        set_word(0, 6'b101010);
        req = 4'b0001;
        sb.push_back('{0, 6'b101010});
        wait_sof(20);
        tick();
        tick();
        chk("t4_bit3", {ser_valid, ser_out}, 2'b11);
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("t4_stall_valid[%0d]", c), ser_valid, 0);
            chk($sformatf("t4_stall_busy[%0d]", c), busy, 1);
        end
        enable = 1'b1;
        wait_frames(3, 30);

        // Asynchronous reset in the middle of a frame, then pointer restart.
        set_word(2, 6'b101010);
        req = 4'b0100;
        sb.push_back('{2, 6'b101010});
        wait_sof(20);
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", {ack, ser_out, ser_valid, ser_sof, ser_eof, src_id, busy}, 0);
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
        set_word(0, 6'b011110);
        set_word(2, 6'b101010);
        req = 4'b0101;
        sb.push_back('{0, 6'b011110});
        sb.push_back('{2, 6'b101010});
        wait_frames(5, 40);

        // Table of held-request scenarios; each row expects exactly one frame.
        auto_drop = 1'b0;
        for (int r = 0; r < 8; r++) begin
            if (tbl[r].rst_before) begin
                req = '0;
                do_reset();
            end
            req     = tbl[r].req;
            data_in = tbl[r].data;
            sb.push_back('{tbl[r].exp_src, tbl[r].exp_word});
            wait_frames(frames_done + 1, 30);
        end
        req       = '0;
        auto_drop = 1'b1;

        repeat (10) tick();
        chk("idle_end_outputs", {ack, ser_valid, ser_sof, ser_eof, busy}, 0);
        chk("idle_src_id_hold", src_id, 3);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
